// File: rtl/tinyalu_responder.sv
// TinyALU command responder: accepts one start/op/A/B command, executes it with
// op-dependent latency and returns a registered result with a one-cycle done pulse.
module tinyalu_responder #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  output logic                done,
  output logic [2*DATA_W-1:0] result,
  output logic                busy,
  output logic                err
);

  localparam int unsigned RES_W = 2 * DATA_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC1 = 2'd1,
    S_MULT  = 2'd2,
    S_REARM = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_MUL = 3'b100,
    OP_RST = 3'b111
  } op_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  // State and datapath registers; reset drops any in-flight command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, operand latch and result computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = op;
          a_d  = A;
          b_d  = B;
          if (op == OP_RST) begin
            res_d   = '0;
            state_d = S_REARM;
          end else if (op == OP_MUL) begin
            cnt_d   = CNT_W'(MUL_LATENCY - 1);
            busy_d  = 1'b1;
            state_d = S_MULT;
          end else begin
            busy_d  = 1'b1;
            state_d = S_EXEC1;
          end
        end
      end

      S_EXEC1: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_REARM;
        case (op_q)
          OP_NOP: ;
          OP_ADD: res_d = RES_W'(a_q) + RES_W'(b_q);
          OP_AND: res_d = RES_W'(a_q & b_q);
          OP_XOR: res_d = RES_W'(a_q ^ b_q);
          default: err_d = 1'b1;
        endcase
      end

      S_MULT: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          res_d   = RES_W'(a_q) * RES_W'(b_q);
          state_d = S_REARM;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_REARM: begin
        // One acceptance per start assertion: wait for start to drop.
        busy_d = 1'b0;
        if (!start) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign done   = done_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign result = res_q;

endmodule

// File: tb/tb_tinyalu_responder.sv
// Scoreboard bench for tinyalu_responder: driver pushes expected responses,
// a monitor pops and compares on every done pulse.
module tb_tinyalu_responder;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned MUL_LATENCY = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        done;
  logic [15:0] result;
  logic        busy;
  logic        err;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec;
  int          n_err;
  int          cyc;
  logic [15:0] model_res;

  tinyalu_responder #(
    .DATA_W     (DATA_W),
    .MUL_LATENCY(MUL_LATENCY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .done  (done),
    .result(result),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: spec-level arithmetic on zero-extended operands.
  task automatic model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] r, output logic e);
    e = 1'b0;
    r = model_res;
    case (o)
      3'd1: r = 16'(int'(a) + int'(b));
      3'd2: r = {8'h00, a & b};
      3'd3: r = {8'h00, a ^ b};
      3'd4: r = 16'(int'(a) * int'(b));
      3'd5, 3'd6: e = 1'b1;
      default: ;
    endcase
  endtask

  task automatic do_cmd(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input int hold);
    exp_t        x;
    logic [15:0] r;
    logic        e;
    int          lat;
    bit          seen;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    lat   = (o == 3'd4) ? int'(MUL_LATENCY) : 1;
    model(o, a, b, r, e);
    model_res = r;
    x.res = r;
    x.err = e;
    x.cyc = cyc + 1 + lat;
    sb.push_back(x);
    @(negedge clk);
    check("busy_after_accept", 32'(busy), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
        check("busy_at_done", 32'(busy), 32'd0);
      end else begin
        A  = 8'($urandom);
        B  = 8'($urandom);
        op = 3'($urandom);
        @(negedge clk);
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    repeat (hold) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_rst_op();
    @(negedge clk);
    start = 1'b1;
    op    = 3'b111;
    A     = 8'($urandom);
    B     = 8'($urandom);
    model_res = 16'h0000;
    @(negedge clk);
    check("rstop_result", 32'(result), 32'd0);
    check("rstop_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          x = sb.pop_front();
          check("result", 32'(result), 32'(x.res));
          check("err", 32'(err), 32'(x.err));
          check("done_cycle", 32'(cyc), 32'(x.cyc));
        end
      end else if (err) begin
        check("err_without_done", 32'(err), 32'd0);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    cyc       = 0;
    model_res = 16'h0000;
    reset     = 1'b1;
    start     = 1'b1;
    op        = 3'd1;
    A         = 8'h01;
    B         = 8'h01;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    do_cmd(3'd1, 8'hFF, 8'hFF, 0);
    check("add_ff_ff", 32'(result), 32'h01FE);
    do_cmd(3'd4, 8'hFF, 8'hFF, 0);
    check("mul_ff_ff", 32'(result), 32'hFE01);
    do_cmd(3'd2, 8'hF0, 8'h3C, 0);
    check("and_f0_3c", 32'(result), 32'h0030);
    do_cmd(3'd3, 8'hF0, 8'h3C, 5);
    check("xor_f0_3c", 32'(result), 32'h00CC);
    do_cmd(3'd4, 8'hE9, 8'h14, 1);
    check("mul_1234", 32'(result), 32'h1234);
    do_cmd(3'd5, 8'h55, 8'hAA, 0);
    check("illegal_hold", 32'(result), 32'h1234);
    do_cmd(3'd0, 8'h11, 8'h22, 0);
    check("noop_hold", 32'(result), 32'h1234);
    do_cmd(3'd4, 8'hFF, 8'hFF, 0);
    do_rst_op();
    check("rstop_cleared", 32'(result), 32'd0);

    // Reset one cycle after a mul is accepted: command is dropped silently.
    @(negedge clk);
    start = 1'b1;
    op    = 3'd4;
    A     = 8'hFF;
    B     = 8'hFF;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset     = 1'b0;
    model_res = 16'h0000;
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_busy_clr", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    repeat (6) @(negedge clk);
    do_cmd(3'd1, 8'h01, 8'h02, 0);
    check("add_after_rst", 32'(result), 32'h0003);

    for (int n = 0; n < 40; n++) begin
      int r;
      r = int'($urandom_range(0, 7));
      if (r == 7) do_rst_op();
      else do_cmd(3'(r), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
      check("model_result", 32'(result), 32'(model_res));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
